rs_cmd_debouncer: RTL



---
 rtl/rs_cmd_pkg.sv | 15 +
 rtl/btn_debounce.sv | 46 ++++
 rtl/rs_cmd_debouncer.sv | 99 +++++++++
 3 files changed

// File: rtl/rs_cmd_pkg.sv
// Shared types for the rs_ff command front end: arbiter states and debounce default.
// Latency: n/a (types and constants only).
// Backpressure: n/a.
package rs_cmd_pkg;

    localparam int DEBOUNCE_CYCLES_DEF = 16;

    typedef enum logic [1:0] {
        IDLE     = 2'b00,
        SET      = 2'b01,
        RESET    = 2'b10,
        CONFLICT = 2'b11
    } arb_state_t;

endpackage

// File: rtl/btn_debounce.sv
// One button channel: 2-flop synchronizer, run-length counter, stable level register.
// Latency: stable flips DEBOUNCE_CYCLES+2 edges after the raw change is first sampled.
// Backpressure: none; free-running every cycle.
module btn_debounce
    import rs_cmd_pkg::*;
#(
    parameter int DEBOUNCE_CYCLES = DEBOUNCE_CYCLES_DEF
) (
    input  logic i_clk,
    input  logic i_rst_n,
    input  logic i_btn,
    output logic o_stable
);

    localparam int CNT_W = $clog2(DEBOUNCE_CYCLES + 1);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);

    logic             r_sync1;
    logic             r_sync2;
    logic             r_stable;
    logic [CNT_W-1:0] r_cnt;

    // Any cycle where the synchronized input agrees with the stable level restarts the run.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_sync1  <= 1'b0;
            r_sync2  <= 1'b0;
            r_stable <= 1'b0;
            r_cnt    <= '0;
        end else begin
            r_sync1 <= i_btn;
            r_sync2 <= r_sync1;
            if (r_sync2 == r_stable) begin
                r_cnt <= '0;
            end else if (r_cnt == CNT_LAST) begin
                r_stable <= ~r_stable;
                r_cnt    <= '0;
            end else begin
                r_cnt <= r_cnt + CNT_W'(1);
            end
        end
    end

    assign o_stable = r_stable;

endmodule

// File: rtl/rs_cmd_debouncer.sv
// Debounces set/reset buttons and arbitrates them into mutually exclusive s/r drives.
// Latency: s/r update DEBOUNCE_CYCLES+3 edges after a raw button change is first sampled.
// Backpressure: none; a simultaneous press locks out both commands until both are released.
module rs_cmd_debouncer
    import rs_cmd_pkg::*;
#(
    parameter int DEBOUNCE_CYCLES = DEBOUNCE_CYCLES_DEF,
    parameter int PULSE_MODE      = 0
) (
    input  logic clk,
    input  logic rst_n,
    input  logic s_btn,
    input  logic r_btn,
    output logic s,
    output logic r,
    output logic s_db,
    output logic r_db,
    output logic conflict
);

    logic       w_s_db;
    logic       w_r_db;
    arb_state_t r_state;
    arb_state_t w_next;
    logic       w_s_nxt;
    logic       w_r_nxt;
    logic       w_conf_nxt;
    logic       r_s;
    logic       r_r;
    logic       r_conflict;

    btn_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_s_db (
        .i_clk    (clk),
        .i_rst_n  (rst_n),
        .i_btn    (s_btn),
        .o_stable (w_s_db)
    );

    btn_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_r_db (
        .i_clk    (clk),
        .i_rst_n  (rst_n),
        .i_btn    (r_btn),
        .o_stable (w_r_db)
    );

    always_comb begin
        w_next = r_state;
        case (r_state)
            IDLE: begin
                case ({w_s_db, w_r_db})
                    2'b10:   w_next = SET;
                    2'b01:   w_next = RESET;
                    2'b11:   w_next = CONFLICT;
                    default: w_next = IDLE;
                endcase
            end
            SET: begin
                if (w_r_db)       w_next = CONFLICT;
                else if (!w_s_db) w_next = IDLE;
            end
            RESET: begin
                if (w_s_db)       w_next = CONFLICT;
                else if (!w_r_db) w_next = IDLE;
            end
            CONFLICT: begin
                if (!w_s_db && !w_r_db) w_next = IDLE;
            end
            default: w_next = IDLE;
        endcase
    end

    // Outputs decode the next state, so s and r can never both be set.
    always_comb begin
        w_s_nxt    = (w_next == SET)   && ((PULSE_MODE == 0) || (r_state == IDLE));
        w_r_nxt    = (w_next == RESET) && ((PULSE_MODE == 0) || (r_state == IDLE));
        w_conf_nxt = (w_next == CONFLICT);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state    <= IDLE;
            r_s        <= 1'b0;
            r_r        <= 1'b0;
            r_conflict <= 1'b0;
        end else begin
            r_state    <= w_next;
            r_s        <= w_s_nxt;
            r_r        <= w_r_nxt;
            r_conflict <= w_conf_nxt;
        end
    end

    assign s        = r_s;
    assign r        = r_r;
    assign s_db     = w_s_db;
    assign r_db     = w_r_db;
    assign conflict = r_conflict;

endmodule
